universal_ff_bank: RTL and testbench

- Parametrised bank of WIDTH flip-flops sharing one clock and synchronous reset; the next-generation storage primitive in the flipflops library.
- Runtime-selectable mode per bank: SR, JK, D or T, with a defined (non-X) policy for the SR 1/1 input case.
- Adds enable gating, complementary outputs that never go X, and SR-conflict reporting: a per-bit flag, a saturating event counter and a sticky error bit.
- Intended for control/status registers and small state holders where the team previously instantiated single-bit SR/JK/D/T flops by hand.

---
 rtl/universal_ff_bank.sv | 153 +++++++++++++++
 tb/tb_universal_ff_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/universal_ff_bank.sv
// ---------------------------------------------------------------------------
// universal_ff_bank
//   A bank of WIDTH flip-flops sharing one clock and one synchronous reset.
//   The whole bank runs in one of four modes, chosen at runtime on each
//   enabled edge: SR, JK, D or T. The bank also reports SR set/reset
//   conflicts three ways: a per-bit flag, a saturating event counter and a
//   sticky error bit.
//
// Parameters
//   WIDTH       number of flip-flops in the bank
//   RESET_VAL   value loaded into q on reset
//   SR11_POLICY action in SR mode when s=r=1:
//                 0 = hold, 1 = reset-dominant, 2 = set-dominant, 3 = toggle
//   CNT_W       width of the conflict event counter
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; overrides en and clr_err
//   en           update enable; when 0, q, qbar and conflict all hold
//   mode         2'b00 SR, 2'b01 JK, 2'b10 D, 2'b11 T
//   a            per-bit s / j / d / t input
//   b            per-bit r / k input; ignored in D and T modes
//   clr_err      synchronous clear of conflict_cnt and err_sticky
//   q            flip-flop state
//   qbar         always exactly ~q
//   conflict     registered per-bit flag: s=r=1 in SR mode on the last
//                enabled edge
//   conflict_cnt saturating count of edges on which any bit conflicted
//   err_sticky   set by the first conflict; held until clr_err or reset
//
// No handshake: every enabled edge is an update.
// ---------------------------------------------------------------------------
module universal_ff_bank #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL   = {WIDTH{1'b0}},
  parameter int                SR11_POLICY = 0,
  parameter int                CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             err_sticky
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] ff_q,       ff_d;
  logic [WIDTH-1:0] ffbar_q,    ffbar_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             err_q,      err_d;
  logic             conflict_event;

  // Next state of each bit. Disabled edges and hold cases keep ff_q.
  always_comb begin
    ff_d = ff_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode)
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: ff_d[i] = ff_q[i];
              2'b01: ff_d[i] = 1'b0;
              2'b10: ff_d[i] = 1'b1;
              default: begin
                // s=r=1 always resolves to a defined value, never X.
                if (SR11_POLICY == 1)      ff_d[i] = 1'b0;
                else if (SR11_POLICY == 2) ff_d[i] = 1'b1;
                else if (SR11_POLICY == 3) ff_d[i] = ~ff_q[i];
                else                       ff_d[i] = ff_q[i];
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00:   ff_d[i] = ff_q[i];
              2'b01:   ff_d[i] = 1'b0;
              2'b10:   ff_d[i] = 1'b1;
              default: ff_d[i] = ~ff_q[i];
            endcase
          end
          MODE_D:  ff_d[i] = a[i];
          default: ff_d[i] = a[i] ? ~ff_q[i] : ff_q[i];
        endcase
      end
    end
  end

  // The complement is a separate register loaded with ~ff_d, so q ^ qbar is
  // all ones on every cycle, including straight out of reset.
  always_comb begin
    ffbar_d = ~ff_d;
  end

  // Conflict detection is only live on enabled SR edges. On a disabled edge
  // the flag holds and nothing is counted.
  always_comb begin
    conflict_d     = conflict_q;
    conflict_event = 1'b0;
    if (en) begin
      conflict_d     = (mode == MODE_SR) ? (a & b) : {WIDTH{1'b0}};
      conflict_event = (mode == MODE_SR) && (|(a & b));
    end
  end

  // A new event beats a simultaneous clr_err: the clear wipes the old
  // history and this edge's event is counted as the first of the new run.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (conflict_event) begin
      cnt_d = clr_err ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
      err_d = 1'b1;
    end else if (clr_err) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ff_q       <= RESET_VAL;
      ffbar_q    <= ~RESET_VAL;
      conflict_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ff_q       <= ff_d;
      ffbar_q    <= ffbar_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign q            = ff_q;
  assign qbar         = ffbar_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_universal_ff_bank
//   Four banks with RESET_VAL=8'hA5 share the same inputs. They differ only
//   in SR11_POLICY (0..3). Bank 0 uses a 3-bit counter so that saturation
//   can be exercised; banks 1..3 use 8-bit counters.
// ---------------------------------------------------------------------------
module tb_universal_ff_bank;

  localparam logic [1:0] SR = 2'b00;
  localparam logic [1:0] JK = 2'b01;
  localparam logic [1:0] DM = 2'b10;
  localparam logic [1:0] TM = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset   = 1'b1;
  logic       en      = 1'b0;
  logic [1:0] mode    = SR;
  logic [7:0] a       = '0;
  logic [7:0] b       = '0;
  logic       clr_err = 1'b0;

  logic [7:0] q_w    [4];
  logic [7:0] qbar_w [4];
  logic [7:0] conf_w [4];
  logic       err_w  [4];
  logic [2:0] cnt0;
  logic [7:0] cnt_a  [1:3];

  universal_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR11_POLICY(0), .CNT_W(3)) u0 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_w[0]), .qbar(qbar_w[0]), .conflict(conf_w[0]), .conflict_cnt(cnt0), .err_sticky(err_w[0]));
  universal_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR11_POLICY(1), .CNT_W(8)) u1 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_w[1]), .qbar(qbar_w[1]), .conflict(conf_w[1]), .conflict_cnt(cnt_a[1]), .err_sticky(err_w[1]));
  universal_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR11_POLICY(2), .CNT_W(8)) u2 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_w[2]), .qbar(qbar_w[2]), .conflict(conf_w[2]), .conflict_cnt(cnt_a[2]), .err_sticky(err_w[2]));
  universal_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR11_POLICY(3), .CNT_W(8)) u3 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q_w[3]), .qbar(qbar_w[3]), .conflict(conf_w[3]), .conflict_cnt(cnt_a[3]), .err_sticky(err_w[3]));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected values for all four banks; eq[p] is the q of the bank with
  // SR11_POLICY=p. ecnt is the count as the 8-bit banks see it (bank 0
  // sees the same value while it stays below 7).
  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] eq [4];
    logic [7:0] econf;
    logic [7:0] ecnt;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic e, input logic [1:0] m,
                     input logic [7:0] va, input logic [7:0] vb, input logic c,
                     input logic [7:0] q0, input logic [7:0] q1,
                     input logic [7:0] q2, input logic [7:0] q3,
                     input logic [7:0] cf, input logic [7:0] cn, input logic er);
    vec_t v;
    v.rst = rst; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
    v.eq[0] = q0; v.eq[1] = q1; v.eq[2] = q2; v.eq[3] = q3;
    v.econf = cf; v.ecnt = cn; v.eerr = er;
    vecs.push_back(v);
  endtask

  // Drive between edges, check 1 time unit after the following rising edge.
  task automatic drive(input logic rst, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
    @(negedge clock);
    reset = rst; en = e; mode = m; a = va; b = vb; clr_err = c;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq [4],
                           input logic [7:0] econf, input logic [7:0] ecnt, input logic eerr);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_q%0d", tag, d),    {24'd0, q_w[d]},    {24'd0, eq[d]});
      check($sformatf("%s_qbar%0d", tag, d), {24'd0, qbar_w[d]}, {24'd0, ~eq[d]});
      check($sformatf("%s_conf%0d", tag, d), {24'd0, conf_w[d]}, {24'd0, econf});
      check($sformatf("%s_err%0d", tag, d),  {31'd0, err_w[d]},  {31'd0, eerr});
    end
    for (int d = 1; d < 4; d++)
      check($sformatf("%s_cnt%0d", tag, d), {24'd0, cnt_a[d]}, {24'd0, ecnt});
  endtask

  logic [7:0] all_q [4];

  task automatic set_all(input logic [7:0] v);
    for (int d = 0; d < 4; d++) all_q[d] = v;
  endtask

  initial begin
    // rst en mode a     b     clr  q(p0) q(p1) q(p2) q(p3) conf  cnt err
    add(1, 0, SR, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0, 0);
    add(1, 1, DM, 8'hFF, 8'h00, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0, 0);
    add(0, 0, SR, 8'hFF, 8'hFF, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0, 0);
    add(0, 0, DM, 8'h3C, 8'h5A, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0, 0);
    add(0, 1, DM, 8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 0, 0);
    add(0, 1, TM, 8'h0F, 8'hFF, 0, 8'h33, 8'h33, 8'h33, 8'h33, 8'h00, 0, 0);
    add(0, 1, TM, 8'h0F, 8'hFF, 0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 0, 0);
    add(0, 1, DM, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 1, JK, 8'hF0, 8'h0F, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 0, 0);
    add(0, 1, JK, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 0, 0);
    add(0, 1, JK, 8'hFF, 8'hFF, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 0, 0);
    add(0, 1, DM, 8'h55, 8'h00, 0, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00, 0, 0);
    // SR 1/1 on every bit: the four policies diverge
    add(0, 1, SR, 8'hFF, 8'hFF, 0, 8'h55, 8'h00, 8'hFF, 8'hAA, 8'hFF, 1, 1);
    add(0, 1, SR, 8'h0F, 8'hF0, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 1, 1);
    // single conflicting bit plus one set bit; one event, not two
    add(0, 1, SR, 8'h03, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h0E, 8'h01, 2, 1);
    add(0, 0, SR, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0E, 8'h0F, 8'h0E, 8'h01, 2, 1);
    add(0, 0, SR, 8'hFF, 8'hFF, 1, 8'h0F, 8'h0E, 8'h0F, 8'h0E, 8'h01, 0, 0);
    add(0, 1, SR, 8'h00, 8'h00, 0, 8'h0F, 8'h0E, 8'h0F, 8'h0E, 8'h00, 0, 0);
    add(0, 1, SR, 8'hF0, 8'h00, 0, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'h00, 0, 0);
    add(0, 1, TM, 8'h00, 8'hFF, 0, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr);
      check_all($sformatf("v%0d", i), vecs[i].eq, vecs[i].econf, vecs[i].ecnt, vecs[i].eerr);
      check($sformatf("v%0d_cnt0", i), {29'd0, cnt0}, {29'd0, vecs[i].ecnt[2:0]});
    end

    // ---- saturation: 10 conflicting edges, bank 0 stops at 7 ----
    drive(0, 1, DM, 8'h55, 8'h00, 0);
    for (int k = 0; k < 10; k++) drive(0, 1, SR, 8'hFF, 8'hFF, 0);
    check("sat_cnt0", {29'd0, cnt0}, 32'd7);
    check("sat_cnt1", {24'd0, cnt_a[1]}, 32'd10);
    check("sat_err0", {31'd0, err_w[0]}, 32'd1);
    check("sat_conf0", {24'd0, conf_w[0]}, 32'hFF);
    // policy 3 toggles on each of 10 edges: back to 55; policy 1 ends at 00
    check("sat_q3", {24'd0, q_w[3]}, 32'h55);
    check("sat_q1", {24'd0, q_w[1]}, 32'h00);

    // ---- clr_err on a conflict edge: event wins ----
    drive(0, 1, SR, 8'h80, 8'h80, 1);
    check("clrev_cnt0", {29'd0, cnt0}, 32'd1);
    check("clrev_cnt2", {24'd0, cnt_a[2]}, 32'd1);
    check("clrev_err0", {31'd0, err_w[0]}, 32'd1);
    check("clrev_conf0", {24'd0, conf_w[0]}, 32'h80);

    // ---- clr_err with no event, while enabled ----
    drive(0, 1, DM, 8'h00, 8'hFF, 1);
    set_all(8'h00);
    check_all("clr", all_q, 8'h00, 8'h00, 1'b0);
    check("clr_cnt0", {29'd0, cnt0}, 32'd0);

    // ---- reset in the middle of a conflict stream ----
    drive(0, 1, SR, 8'hFF, 8'hFF, 0);
    drive(0, 1, SR, 8'hFF, 8'hFF, 0);
    check("pre_rst_cnt1", {24'd0, cnt_a[1]}, 32'd2);
    drive(1, 1, SR, 8'hFF, 8'hFF, 0);
    set_all(8'hA5);
    check_all("midrst", all_q, 8'h00, 8'h00, 1'b0);
    check("midrst_cnt0", {29'd0, cnt0}, 32'd0);
    // first edge after reset release uses its own inputs
    drive(0, 1, DM, 8'h12, 8'h00, 0);
    set_all(8'h12);
    check_all("postrst", all_q, 8'h00, 8'h00, 1'b0);

    // ---- conflicting inputs with en=0 are neither flagged nor counted ----
    drive(0, 0, SR, 8'hFF, 8'hFF, 0);
    drive(0, 0, SR, 8'hFF, 8'hFF, 0);
    check_all("dis", all_q, 8'h00, 8'h00, 1'b0);
    check("dis_cnt0", {29'd0, cnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
